// File: rtl/branch_pc_sequencer.sv
// Multi-cycle RV32I PC sequencer: fetch handshake, instruction hold, branch/jump resolution.
// Optional misaligned-target trap built in with `define MISALIGN_TRAP_EN.
module branch_pc_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 15,
   parameter int unsigned CNT_W         = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] insn,
   output logic        insn_valid,
   input  logic        exec_done,
   input  logic        EQ,
   input  logic        LS,
   input  logic        LU,
   input  logic [31:0] jalr_base,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        branch_taken,
   output logic        fetch_err,
   output logic        trap
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_UPDATE, S_HALT} state_t;

   localparam logic [6:0]  OP_BR   = 7'b1100011;
   localparam logic [6:0]  OP_JAL  = 7'b1101111;
   localparam logic [6:0]  OP_JALR = 7'b1100111;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d, insn_q, insn_d, npc_q, npc_d;
   logic              taken_q, taken_d;
   logic              req_q, req_d, ivld_q, ivld_d, bt_q, bt_d, ferr_q, ferr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0]       imm_b, imm_j, imm_i, tgt_c, next_c;
   logic              cond_c, taken_c;

   always_comb begin
      imm_b = {{20{insn_q[31]}}, insn_q[7], insn_q[30:25], insn_q[11:8], 1'b0};
      imm_j = {{12{insn_q[31]}}, insn_q[19:12], insn_q[20], insn_q[30:21], 1'b0};
      imm_i = {{21{insn_q[31]}}, insn_q[30:20]};
      case (insn_q[14:12])
         3'b000:  cond_c = EQ;
         3'b001:  cond_c = ~EQ;
         3'b100:  cond_c = LS;
         3'b101:  cond_c = ~LS;
         3'b110:  cond_c = LU;
         3'b111:  cond_c = ~LU;
         default: cond_c = 1'b0;
      endcase
      case (insn_q[6:0])
         OP_BR: begin
            taken_c = cond_c;
            tgt_c   = cond_c ? pc_q + imm_b : pc_q + 32'd4;
         end
         OP_JAL: begin
            taken_c = 1'b1;
            tgt_c   = pc_q + imm_j;
         end
         OP_JALR: begin
            taken_c = 1'b1;
            tgt_c   = (jalr_base + imm_i) & ~32'h1;
         end
         default: begin
            taken_c = 1'b0;
            tgt_c   = pc_q + 32'd4;
         end
      endcase
`ifdef MISALIGN_TRAP_EN
      next_c = tgt_c;
`else
      // Without the trap, a misaligned target is silently word-aligned.
      next_c = tgt_c & ~32'h3;
`endif
   end

`ifdef MISALIGN_TRAP_EN
   logic trap_q, trap_d;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      insn_d  = insn_q;
      npc_d   = npc_q;
      taken_d = taken_q;
      ferr_d  = ferr_q;
      cnt_d   = cnt_q;
`ifdef MISALIGN_TRAP_EN
      trap_d  = trap_q;
`endif
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               insn_d  = imem_rdata;
               cnt_d   = '0;
               state_d = S_EXEC;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(FETCH_TIMEOUT)) begin
                  ferr_d  = 1'b1;
                  state_d = S_HALT;
               end
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               npc_d   = next_c;
               taken_d = taken_c;
               state_d = S_UPDATE;
`ifdef MISALIGN_TRAP_EN
               if (taken_c && (tgt_c[1:0] != 2'b00)) begin
                  trap_d  = 1'b1;
                  state_d = S_HALT;
               end
`endif
            end
         end
         S_UPDATE: begin
            pc_d    = npc_q;
            state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
      // Outputs are registered alongside the state they decode.
      req_d  = (state_d == S_FETCH);
      ivld_d = (state_d == S_EXEC);
      bt_d   = (state_d == S_UPDATE) && taken_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         insn_q  <= NOP;
         npc_q   <= RESET_PC;
         taken_q <= 1'b0;
         req_q   <= 1'b0;
         ivld_q  <= 1'b0;
         bt_q    <= 1'b0;
         ferr_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef MISALIGN_TRAP_EN
         trap_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         insn_q  <= insn_d;
         npc_q   <= npc_d;
         taken_q <= taken_d;
         req_q   <= req_d;
         ivld_q  <= ivld_d;
         bt_q    <= bt_d;
         ferr_q  <= ferr_d;
         cnt_q   <= cnt_d;
`ifdef MISALIGN_TRAP_EN
         trap_q  <= trap_d;
`endif
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = pc_q;
   assign insn         = insn_q;
   assign insn_valid   = ivld_q;
   assign pc           = pc_q;
   assign pc_plus4     = pc_q + 32'd4;
   assign branch_taken = bt_q;
   assign fetch_err    = ferr_q;
`ifdef MISALIGN_TRAP_EN
   assign trap         = trap_q;
`else
   assign trap         = 1'b0;
`endif

endmodule
